pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces per-stage hold enables, flushes and a MEM/WB bubble.
- Resolves three conditions: load-use hazards, taken-branch redirects, and multi-cycle data-memory waits.
- A timeout FSM halts the pipeline on a stuck memory.
- Sits beside the forwarding unit, which still covers every non-load RAW hazard.

Parameters:
- MAX_WAIT, 16: maximum consecutive cycles MEM may wait on mem_ready before halting (2..255).
- CNT_W, 8: width of the internal wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memRead  in  1  instruction in EX is a load.
- ex_regWriteAddr  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads a bubble (all controls 0).
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  MEM/WB captures regWrite=0, memtoReg=0.
- halted  out  1  sticky; memory timeout occurred.

Behaviour:
- Reset is asynchronous. While rst_n=0:
  - state=RUN, wait_cnt=0, halted=0.
  - All enables=0; ifid_flush=idex_flush=memwb_bubble=0.
- After rst_n deasserts, RUN defaults apply from the first clock.
- FSM states are RUN, MEM_WAIT and HALT. Outputs are combinational from the state plus current inputs (zero-latency Mealy).
- Load-use detect (lu):
  - lu = ex_memRead & ex_regWriteAddr!=0 & (ex_regWriteAddr==id_rs | (id_uses_rt & ex_regWriteAddr==id_rt)).
- Memory stall (ms): ms = mem_req & ~mem_ready.
- RUN, output priority ms > branch > lu > normal:
  - ms: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, no flushes. Next state is MEM_WAIT and wait_cnt=1.
  - ex_branch_taken: all enables=1, ifid_flush=1, idex_flush=1. The branch kills the lu victim, so lu is ignored.
  - lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. This inserts exactly one bubble; next cycle the load is in MEM and lu clears naturally.
  - Normal: all enables=1, flushes=0, memwb_bubble=0.
- MEM_WAIT:
  - mem_ready=0: hold as in the ms row and increment wait_cnt.
    - If wait_cnt==MAX_WAIT-1 at the clock edge, next state is HALT and halted is set.
  - mem_ready=1: apply the RUN priority for the remaining conditions (branch/lu/normal, ms excluded), next state is RUN and wait_cnt=0.
  - A branch or lu condition present during the wait is frozen in place and acted on in the release cycle.
- HALT:
  - All enables=0, memwb_bubble=1, flushes=0.
  - halted=1 until reset. No input exits HALT.
- Boundaries:
  - MAX_WAIT cycles of waiting total, then halt.
  - mem_ready arriving in the same cycle as wait_cnt==MAX_WAIT-1 wins: return to RUN, no halt.
  - ex_regWriteAddr==0 never causes a stall.
  - rst_n asserted mid-wait returns to RUN immediately, asynchronously.

Optional Feature:
- Macro PIPE_PERF_EN.
- When defined, add three outputs, all reset to 0, saturating at all-ones, and cleared only by reset:
  - perf_stall_cnt [31:0]: counts cycles with pc_en=0 outside HALT.
  - perf_flush_cnt [15:0]: counts branch flush cycles.
  - perf_lu_cnt [15:0]: counts load-use bubbles.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2);
  - register-0 constant 5'd0;
  - default MAX_WAIT.
- One natural sub-module, hazard_detect: purely combinational lu comparator, reusable by the forwarding unit.
- FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Load-use stall:
  - Stimulus: ex_memRead=1, ex_regWriteAddr=8, id_rs=8.
  - Response: one cycle with pc_en=0, ifid_en=0, idex_flush=1; the following cycle (ex_memRead=0) all enables=1.
  - Repeat with ex_regWriteAddr=0: no stall.
- Branch flush:
  - Stimulus: ex_branch_taken=1 in the same cycle as lu=1.
  - Response: ifid_flush=idex_flush=1, pc_en=1, no load-use hold.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then 1.
  - Response: 3 cycles with all enables=0 and memwb_bubble=1; release cycle all enables=1; state back to RUN.
- Timeout:
  - Stimulus: MAX_WAIT=4, mem_ready held 0.
  - Response: halted=1 after the 4th waiting edge; all enables stay 0.
  - Variant: mem_ready=1 exactly in the 4th cycle gives no halt.
- Async reset:
  - Stimulus: drop rst_n mid MEM_WAIT, between clock edges.
  - Response: outputs reach reset values immediately; halted clears.
  - After release, the first cycle with mem_req=0 gives all enables=1.
- Performance counters (PIPE_PERF_EN):
  - Stimulus: run the above sequence.
  - Response: perf_lu_cnt=1, perf_flush_cnt=1, perf_stall_cnt equals the total stall cycles outside HALT.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int DEF_MAX_WAIT = 16;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stage enables/flushes out (perf counters with PIPE_PERF_EN)
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic id_uses_rt;
   logic ex_memRead;
   logic [4:0] ex_regWriteAddr;
   logic ex_branch_taken;
   logic mem_req;
   logic mem_ready;
   logic pc_en;
   logic ifid_en;
   logic ifid_flush;
   logic idex_en;
   logic idex_flush;
   logic exmem_en;
   logic memwb_bubble;
   logic halted;
`ifdef PIPE_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
   logic [15:0] perf_lu_cnt;
`endif
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memRead, ex_regWriteAddr, ex_branch_taken, mem_req, mem_ready,
      input pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, halted
`ifdef PIPE_PERF_EN
      , input perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
`endif
   );
   modport slave (
      input id_rs, id_rt, id_uses_rt, ex_memRead, ex_regWriteAddr, ex_branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, halted
`ifdef PIPE_PERF_EN
      , output perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX and the sources in ID
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input logic [4:0] idRs,
   input logic [4:0] idRt,
   input logic idUsesRt,
   input logic exMemRead,
   input logic [4:0] exRegWriteAddr,
   output logic lu
);
   assign lu = exMemRead && exRegWriteAddr != REG_ZERO &&
               (exRegWriteAddr == idRs || (idUsesRt && exRegWriteAddr == idRt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hold/flush sequencer with memory-timeout halt.
// Define PIPE_PERF_EN to add saturating stall/flush/load-use counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);
   state_t state, nextState;
   logic [CNT_W-1:0] waitCnt, nextCnt;
   logic lu, hold, brSel, luSel;
   hazard_detect uHazard (
      .idRs(bus.id_rs),
      .idRt(bus.id_rt),
      .idUsesRt(bus.id_uses_rt),
      .exMemRead(bus.ex_memRead),
      .exRegWriteAddr(bus.ex_regWriteAddr),
      .lu(lu)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RUN;
         waitCnt <= '0;
      end else begin
         state <= nextState;
         waitCnt <= nextCnt;
      end
   always_comb begin
      nextState = state;
      nextCnt = waitCnt;
      hold = 1'b0;
      case (state)
         RUN: begin
            hold = bus.mem_req && !bus.mem_ready;
            nextState = hold ? MEM_WAIT : RUN;
            nextCnt = hold ? CNT_W'(1) : '0;
         end
         MEM_WAIT: begin
            hold = !bus.mem_ready;
            nextState = bus.mem_ready ? RUN : (waitCnt == LAST_WAIT ? HALT : MEM_WAIT);
            nextCnt = bus.mem_ready ? '0 : waitCnt + CNT_W'(1);
         end
         HALT: hold = 1'b1;
         default: nextState = RUN;
      endcase
   end
   // a taken branch squashes the load-use victim, so it outranks lu
   assign brSel = !hold && bus.ex_branch_taken;
   assign luSel = !hold && !bus.ex_branch_taken && lu;
   assign bus.pc_en = rst_n && !hold && !luSel;
   assign bus.ifid_en = rst_n && !hold && !luSel;
   assign bus.ifid_flush = rst_n && brSel;
   assign bus.idex_en = rst_n && !hold;
   assign bus.idex_flush = rst_n && (brSel || luSel);
   assign bus.exmem_en = rst_n && !hold;
   assign bus.memwb_bubble = rst_n && hold;
   assign bus.halted = state == HALT;
`ifdef PIPE_PERF_EN
   logic [31:0] perfStall;
   logic [15:0] perfFlush, perfLu;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perfStall <= '0;
         perfFlush <= '0;
         perfLu <= '0;
      end else begin
         if (!bus.pc_en && state != HALT && !(&perfStall)) perfStall <= perfStall + 32'd1;
         if (brSel && !(&perfFlush)) perfFlush <= perfFlush + 16'd1;
         if (luSel && !(&perfLu)) perfLu <= perfLu + 16'd1;
      end
   assign bus.perf_stall_cnt = perfStall;
   assign bus.perf_flush_cnt = perfFlush;
   assign bus.perf_lu_cnt = perfLu;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a cycle-level reference model
module tb_pipe_hazard_ctrl;
   localparam int MW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int waitCycles = 0;
   bit mHalt = 1'b0;
   int pStall = 0;
   int pFlush = 0;
   int pLu = 0;
   always #5 clk = ~clk;
   pipe_hazard_ctrl_if bus ();
   pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   // output vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_bubble halted
   localparam logic [7:0] NORMAL = 8'b1101_0100;
   localparam logic [7:0] BRANCH = 8'b1111_1100;
   localparam logic [7:0] LDUSE = 8'b0001_1100;
   localparam logic [7:0] STALL = 8'b0000_0010;
   localparam logic [7:0] HALTV = 8'b0000_0011;
   function automatic logic [7:0] outs();
      return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
              bus.exmem_en, bus.memwb_bubble, bus.halted};
   endfunction
   function automatic logic [7:0] expOut();
      bit stall, ldUse;
      if (!rst_n) return 8'h00;
      if (mHalt) return HALTV;
      stall = (waitCycles > 0) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
      if (stall) return STALL;
      if (bus.ex_branch_taken) return BRANCH;
      ldUse = bus.ex_memRead && bus.ex_regWriteAddr != 5'd0 &&
              (bus.ex_regWriteAddr == bus.id_rs || (bus.id_uses_rt && bus.ex_regWriteAddr == bus.id_rt));
      return ldUse ? LDUSE : NORMAL;
   endfunction
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic checkPerf(string tag);
`ifdef PIPE_PERF_EN
      check({tag, "_pstall"}, bus.perf_stall_cnt, 32'(pStall));
      check({tag, "_pflush"}, 32'(bus.perf_flush_cnt), 32'(pFlush));
      check({tag, "_plu"}, 32'(bus.perf_lu_cnt), 32'(pLu));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask
   task automatic drive(logic [4:0] rs, logic [4:0] rt, logic ut, logic mr, logic [4:0] wa,
                        logic br, logic req, logic rdy);
      bus.id_rs = rs;
      bus.id_rt = rt;
      bus.id_uses_rt = ut;
      bus.ex_memRead = mr;
      bus.ex_regWriteAddr = wa;
      bus.ex_branch_taken = br;
      bus.mem_req = req;
      bus.mem_ready = rdy;
   endtask
   task automatic cyc(string tag);
      logic [7:0] e;
      bit stall;
      #2;
      e = expOut();
      check(tag, 32'(outs()), 32'(e));
      checkPerf(tag);
      @(posedge clk);
      if (rst_n && !mHalt) begin
         if (!e[7]) pStall++;
         if (e == BRANCH) pFlush++;
         if (e == LDUSE) pLu++;
         stall = (waitCycles > 0) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
         if (stall) begin
            waitCycles++;
            if (waitCycles == MW) mHalt = 1'b1;
         end else waitCycles = 0;
      end
      #1;
   endtask
   task automatic resetPulse(string tag);
      #3 rst_n = 1'b0;
      #1;
      check({tag, "_async"}, 32'(outs()), 32'h0);
      waitCycles = 0;
      mHalt = 1'b0;
      pStall = 0;
      pFlush = 0;
      pLu = 0;
      checkPerf(tag);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check("reset", 32'(outs()), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("normal");
      drive(8, 3, 0, 1, 8, 0, 0, 1);
      cyc("lu_rs");
      drive(8, 3, 0, 0, 8, 0, 0, 1);
      cyc("lu_after");
      drive(1, 8, 1, 1, 8, 0, 0, 1);
      cyc("lu_rt");
      drive(1, 8, 0, 1, 8, 0, 0, 1);
      cyc("rt_unused");
      drive(0, 0, 1, 1, 0, 0, 0, 1);
      cyc("lu_r0");
      drive(8, 8, 1, 1, 8, 1, 0, 1);
      cyc("branch_lu");
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) cyc("mem_wait");
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      cyc("mem_release");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("after_release");
      drive(8, 0, 0, 1, 8, 0, 1, 0);
      repeat (2) cyc("wait_lu_frozen");
      drive(8, 0, 0, 1, 8, 0, 1, 1);
      cyc("release_lu");
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (4) cyc("timeout_wait");
      cyc("halted");
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      cyc("halt_sticky");
      resetPulse("rst_halt");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("post_rst");
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) cyc("late_wait");
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      cyc("late_ready");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("no_halt");
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (2) cyc("pre_rst_wait");
      resetPulse("rst_wait");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("post_rst_wait");
      for (int i = 0; i < 400; i++) begin
         if (mHalt && $urandom_range(0, 3) == 0) resetPulse("rand_rst");
         else if ($urandom_range(0, 79) == 0) resetPulse("rand_rst");
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
         cyc("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
